// File: rtl/neureka_outfeat_buffer_pkg.sv
// Types and sizing shared by the output feature buffer and its register file.
package neureka_outfeat_buffer_pkg;

    localparam int unsigned NEUREKA_BLOCK_SIZE          = 32;
    localparam int unsigned NEUREKA_OUTFEAT_BUFFER_SIZE = 2048;
    localparam int unsigned OB_NW = NEUREKA_OUTFEAT_BUFFER_SIZE / NEUREKA_BLOCK_SIZE;
    localparam int unsigned OB_AW = $clog2(OB_NW);

    typedef enum logic [1:0] {
        OB_IDLE   = 2'd0,
        OB_LOAD   = 2'd1,
        OB_STREAM = 2'd2
    } state_outfeat_buffer_t;

    typedef struct packed {
        logic               goto_load;
        logic               goto_stream;
        logic [OB_AW:0]     store_len;
        logic [OB_NW-1:0]   store_mask;
    } ctrl_outfeat_buffer_t;

    typedef struct packed {
        state_outfeat_buffer_t state;
        logic [OB_AW-1:0]      word_cnt;
        logic                  done;
    } flags_outfeat_buffer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake with data and byte strobe.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_outfeat_buffer_regfile.sv
// Flip-flop word store: all words written at once, one combinational read port.
module neureka_outfeat_buffer_regfile #(
    parameter int unsigned NW = 64,
    parameter int unsigned DS = 256,
    parameter int unsigned AW = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             test_mode_i,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [NW*DS-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [DS-1:0]    rdata_o
);

    logic [DS-1:0] mem_q [NW];

    // test_mode_i only matters for a gate-level clock gate, absent in this flop model
    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned w = 0; w < NW; w++) mem_q[w] <= '0;
        end else if (clear_i) begin
            for (int unsigned w = 0; w < NW; w++) mem_q[w] <= '0;
        end else if (we_i) begin
            for (int unsigned w = 0; w < NW; w++) mem_q[w] <= wdata_i[w*DS +: DS];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neureka_outfeat_buffer.sv
// Output feature buffer: parallel tile capture, masked word-by-word streaming.
module neureka_outfeat_buffer
    import neureka_outfeat_buffer_pkg::*;
#(
    parameter int unsigned OUTPUT_BUF_SIZE = NEUREKA_OUTFEAT_BUFFER_SIZE,
    parameter int unsigned BLOCK_SIZE      = NEUREKA_BLOCK_SIZE,
    parameter int unsigned DW              = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  ctrl_outfeat_buffer_t  ctrl_i,
    output flags_outfeat_buffer_t flags_o,
    hwpe_stream_intf_stream.sink   feat_i [OUTPUT_BUF_SIZE-1:0],
    hwpe_stream_intf_stream.source feat_o [BLOCK_SIZE-1:0]
);

    localparam int unsigned NW = OUTPUT_BUF_SIZE / BLOCK_SIZE;
    localparam int unsigned AW = $clog2(NW);
    localparam int unsigned DS = DW * BLOCK_SIZE;

    state_outfeat_buffer_t state_q, state_d;
    logic [AW-1:0]         word_cnt_q, word_cnt_d;
    logic                  done_q, done_d;

    logic [AW:0]              len_eff;
    logic [AW:0]              cnt_inc;
    logic                     len_zero, last_word, cur_mask, advance;
    logic                     in_ready_c, out_valid_c, load_hs, out_hs;
    logic [OUTPUT_BUF_SIZE*DW-1:0] wdata;
    logic [DS-1:0]            rdata;

    // Oversized lengths saturate to the full tile
    assign len_eff   = (ctrl_i.store_len > (AW+1)'(NW)) ? (AW+1)'(NW) : ctrl_i.store_len;
    assign len_zero  = (len_eff == '0);
    assign cnt_inc   = {1'b0, word_cnt_q} + (AW+1)'(1);
    assign last_word = len_zero | (cnt_inc >= len_eff);
    assign cur_mask  = ctrl_i.store_mask[word_cnt_q];
    assign load_hs   = in_ready_c & feat_i[0].valid;
    assign out_hs    = out_valid_c & feat_o[0].ready;
    assign advance   = len_zero | ~cur_mask | out_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
        if (!rst_ni) begin
            state_q    <= OB_IDLE;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin : p_next
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        done_d     = 1'b0;
        if (clear_i) begin
            state_d    = OB_IDLE;
            word_cnt_d = '0;
        end else if (enable_i) begin
            case (state_q)
                OB_IDLE: begin
                    if (ctrl_i.goto_load)        state_d = OB_LOAD;
                    else if (ctrl_i.goto_stream) state_d = OB_STREAM;
                end
                OB_LOAD: begin
                    if (load_hs) begin
                        state_d    = OB_STREAM;
                        word_cnt_d = '0;
                    end
                end
                OB_STREAM: begin
                    if (advance) begin
                        if (last_word) begin
                            state_d    = OB_IDLE;
                            word_cnt_d = '0;
                            done_d     = 1'b1;
                        end else begin
                            word_cnt_d = cnt_inc[AW-1:0];
                        end
                    end
                end
                default: state_d = OB_IDLE;
            endcase
        end
    end

    // Handshakes are held off while disabled or clearing so nothing moves
    always_comb begin : p_out
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        if (enable_i && !clear_i) begin
            case (state_q)
                OB_LOAD:   in_ready_c  = 1'b1;
                OB_STREAM: out_valid_c = ~len_zero & cur_mask;
                default: ;
            endcase
        end
    end

    for (genvar ii = 0; ii < OUTPUT_BUF_SIZE; ii++) begin : g_in
        logic unused_lane;
        assign feat_i[ii].ready   = in_ready_c;
        assign wdata[ii*DW +: DW] = feat_i[ii].data;
        assign unused_lane        = ^{feat_i[ii].valid, feat_i[ii].strb};
    end

    for (genvar jj = 0; jj < BLOCK_SIZE; jj++) begin : g_out
        logic unused_ready;
        assign feat_o[jj].valid = out_valid_c;
        assign feat_o[jj].data  = rdata[jj*DW +: DW];
        assign feat_o[jj].strb  = '1;
        assign unused_ready     = feat_o[jj].ready;
    end

    neureka_outfeat_buffer_regfile #(
        .NW (NW),
        .DS (DS),
        .AW (AW)
    ) i_regfile (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .clear_i     (clear_i),
        .we_i        (load_hs),
        .wdata_i     (wdata),
        .raddr_i     (word_cnt_q),
        .rdata_o     (rdata)
    );

    assign flags_o.state    = state_q;
    assign flags_o.word_cnt = word_cnt_q;
    assign flags_o.done     = done_q;

endmodule

// File: tb/tb_neureka_outfeat_buffer.sv
// Randomized bench for neureka_outfeat_buffer against a tile/queue reference model.
module tb_neureka_outfeat_buffer;
    import neureka_outfeat_buffer_pkg::*;

    localparam int unsigned OBS = NEUREKA_OUTFEAT_BUFFER_SIZE;
    localparam int unsigned BS  = NEUREKA_BLOCK_SIZE;
    localparam int unsigned NW  = OBS / BS;
    localparam int unsigned DW  = 8;

    logic clk_i = 1'b0;
    logic rst_ni, test_mode_i, enable_i, clear_i;
    ctrl_outfeat_buffer_t  ctrl;
    flags_outfeat_buffer_t flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) feat_in  [OBS-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) feat_out [BS-1:0]  ();

    logic [7:0] in_data  [OBS];
    logic [7:0] mdl_buf  [OBS];
    logic [7:0] out_data [BS];
    logic       in_valid, in_ready, out_ready, out_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < OBS; g++) begin : g_in
        assign feat_in[g].data  = in_data[g];
        assign feat_in[g].valid = in_valid;
        assign feat_in[g].strb  = 1'b1;
    end
    for (genvar g = 0; g < BS; g++) begin : g_out
        assign out_data[g]      = feat_out[g].data;
        assign feat_out[g].ready = out_ready;
    end
    assign in_ready  = feat_in[0].ready;
    assign out_valid = feat_out[0].valid;

    neureka_outfeat_buffer i_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .ctrl_i      (ctrl),
        .flags_o     (flags),
        .feat_i      (feat_in),
        .feat_o      (feat_out)
    );

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] model_word(input int w);
        logic [255:0] r = '0;
        for (int j = 0; j < BS; j++) r[j*8 +: 8] = mdl_buf[w*BS + j];
        return r;
    endfunction

    function automatic logic [255:0] dut_word();
        logic [255:0] r = '0;
        for (int j = 0; j < BS; j++) r[j*8 +: 8] = out_data[j];
        return r;
    endfunction

    function automatic int exp_done_cycle(input int len);
        int l = (len > int'(NW)) ? int'(NW) : len;
        return (l == 0) ? 1 : l;
    endfunction

    // pat 1: byte = (w*32+j)&0xFF, pat 0: random bytes
    task automatic load_tile(input int pat, input logic both);
        @(negedge clk_i);
        ctrl.goto_load   = 1'b1;
        ctrl.goto_stream = both;
        @(negedge clk_i);
        ctrl.goto_load   = 1'b0;
        ctrl.goto_stream = 1'b0;
        #1;
        check_eq(both ? "prio_load_state" : "load_state", 256'(flags.state), 256'(OB_LOAD));
        for (int i = 0; i < int'(OBS); i++) begin
            in_data[i] = (pat == 1) ? 8'(((i / BS) * 32 + (i % BS)) & 255) : 8'($urandom);
        end
        in_valid = 1'b1;
        #1;
        for (int n = 0; n < 10 && !in_ready; n++) begin
            @(negedge clk_i);
            #1;
        end
        check_eq("load_ready", 256'(in_ready), 256'(1));
        for (int i = 0; i < int'(OBS); i++) mdl_buf[i] = in_data[i];
    endtask

    task automatic start_stream();
        @(negedge clk_i);
        ctrl.goto_stream = 1'b1;
    endtask

    // rmode 0: ready high, 1: 1,0,0,1 pattern, 2: random
    task automatic stream_check(input string tag, input int len, input logic [63:0] mask,
                                input int rmode, input int exp_done, input int en_lo, input int en_hi);
        int   exp_q [$];
        int   done_at = -1;
        int   frozen = 0;
        logic prev_stall = 1'b0;
        int   l = (len > int'(NW)) ? int'(NW) : len;
        for (int w = 0; w < l; w++) if (mask[w]) exp_q.push_back(w);
        ctrl.store_len  = 7'(len);
        ctrl.store_mask = mask;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            ctrl.goto_load   = 1'b0;
            ctrl.goto_stream = 1'b0;
            in_valid         = 1'b0;
            enable_i         = !(c >= en_lo && c < en_hi);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (flags.done) begin
                done_at = c;
                check_eq({tag, "_done_idle"}, 256'(flags.state), 256'(OB_IDLE));
                break;
            end
            if (!enable_i) begin
                check_eq({tag, "_dis_valid"}, 256'(out_valid), 256'(0));
                if (c == en_lo) frozen = int'(flags.word_cnt);
                else check_eq({tag, "_dis_cnt"}, 256'(flags.word_cnt), 256'(frozen));
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) check_eq({tag, "_stall_hold"}, 256'(out_valid), 256'(1));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq({tag, "_extra_valid"}, 256'(out_valid), 256'(0));
                end else begin
                    check_eq({tag, "_cnt"}, 256'(flags.word_cnt), 256'(exp_q[0]));
                    check_eq({tag, "_data"}, dut_word(), model_word(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid & ~out_ready;
        end
        check_eq({tag, "_done_seen"}, 256'(done_at >= 0), 256'(1));
        check_eq({tag, "_left"}, 256'(exp_q.size()), 256'(0));
        if (exp_done >= 0) check_eq({tag, "_done_cyc"}, 256'(done_at), 256'(exp_done));
        @(negedge clk_i);
        enable_i = 1'b1;
        #1;
        check_eq({tag, "_done_pulse"}, 256'(flags.done), 256'(0));
    endtask

    initial begin
        logic [63:0] m;
        int          len, rmode;
        rst_ni = 1'b0; test_mode_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
        ctrl = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < int'(OBS); i++) begin
            in_data[i] = 8'h00;
            mdl_buf[i] = 8'h00;
        end
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_state", 256'(flags.state), 256'(OB_IDLE));
        check_eq("rst_cnt",   256'(flags.word_cnt), 256'(0));
        check_eq("rst_done",  256'(flags.done), 256'(0));
        check_eq("rst_ready", 256'(in_ready), 256'(0));
        check_eq("rst_valid", 256'(out_valid), 256'(0));
        rst_ni = 1'b1;

        start_stream();
        stream_check("rst_buf", 64, '1, 0, 64, -1, -1);

        load_tile(1, 1'b0);
        stream_check("full", 64, '1, 0, 64, -1, -1);

        load_tile(0, 1'b0);
        stream_check("bp", 64, '1, 1, -1, -1, -1);

        load_tile(0, 1'b0);
        stream_check("mask", 8, 64'hA6, 0, 8, -1, -1);

        start_stream();
        stream_check("len0", 0, '1, 0, 1, -1, -1);

        start_stream();
        stream_check("len100", 100, '1, 0, 64, -1, -1);

        m = {$urandom, $urandom};
        m[15] = 1'b0;
        start_stream();
        stream_check("lastskip", 16, m, 0, 16, -1, -1);

        start_stream();
        stream_check("enable", 64, '1, 0, 67, 20, 23);

        load_tile(0, 1'b1);
        stream_check("prio", 64, '1, 2, -1, -1, -1);

        for (int it = 0; it < 6; it++) begin
            if (it % 2 == 0) load_tile(0, 1'b0);
            else start_stream();
            len   = int'($urandom_range(0, 80));
            m     = {$urandom, $urandom};
            rmode = int'($urandom_range(0, 2));
            stream_check("rand", len, m, rmode, (rmode == 0) ? exp_done_cycle(len) : -1, -1, -1);
        end

        // Clear while streaming word 10
        load_tile(0, 1'b0);
        ctrl.store_len  = 7'd64;
        ctrl.store_mask = '1;
        begin
            int n = 0;
            do begin
                @(negedge clk_i);
                in_valid  = 1'b0;
                out_ready = 1'b1;
                #1;
                n++;
            end while (flags.word_cnt != 6'd10 && n < 40);
        end
        check_eq("clr_reach", 256'(flags.word_cnt), 256'(10));
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        check_eq("clr_state", 256'(flags.state), 256'(OB_IDLE));
        check_eq("clr_cnt",   256'(flags.word_cnt), 256'(0));
        check_eq("clr_done",  256'(flags.done), 256'(0));
        for (int i = 0; i < int'(OBS); i++) mdl_buf[i] = 8'h00;
        start_stream();
        stream_check("clr_zero", 64, '1, 0, 64, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
